// File: rtl/leds_racer_pkg.sv
// Shared definitions for the LED racer blocks: WS2812 timing defaults,
// decoder error codes, decoder state encoding and pixel payload type.
package leds_racer_pkg;

    localparam int unsigned BITS_PER_PIXEL     = 24;

    // WS2812 timing defaults, in samples of a 50 MHz clock
    localparam int unsigned DEF_T1_MIN_CLK     = 30;
    localparam int unsigned DEF_T_HIGH_MAX_CLK = 100;
    localparam int unsigned DEF_T_RESET_CLK    = 2500;

    localparam int unsigned DEF_MAX_POS        = 109;
    localparam int unsigned DEF_IDX_W          = 7;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE           = 2'b00;
    localparam logic [1:0] ERR_HIGH_TOO_LONG  = 2'b01;
    localparam logic [1:0] ERR_PARTIAL_PIXEL  = 2'b10;
    localparam logic [1:0] ERR_PIXEL_OVERFLOW = 2'b11;

    // Decoder state encoding
    localparam logic [1:0] ST_SYNC = 2'b00;
    localparam logic [1:0] ST_LOW  = 2'b01;
    localparam logic [1:0] ST_HIGH = 2'b10;

    // Pixel payload: G[23:16] R[15:8] B[7:0], first-received bit in bit 23
    typedef logic [BITS_PER_PIXEL-1:0] grb_t;

endpackage

// File: rtl/ws2812_line_decoder_if.sv
// Decoder report bus: pixel strobe/data, frame close strobe/count, error strobe/code.
//   master: driven by the decoder; slave: consumed by a monitor/checker.
interface ws2812_line_decoder_if
    import leds_racer_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W
);
    logic             pixel_valid;
    logic [IDX_W-1:0] pixel_index;
    grb_t             pixel_grb;
    logic             frame_done;
    logic [IDX_W-1:0] frame_pixel_count;
    logic             err_valid;
    logic [1:0]       err_code;

    modport master (
        output pixel_valid, pixel_index, pixel_grb,
        output frame_done, frame_pixel_count,
        output err_valid, err_code
    );

    modport slave (
        input pixel_valid, pixel_index, pixel_grb,
        input frame_done, frame_pixel_count,
        input err_valid, err_code
    );
endinterface

// File: rtl/line_sync_edge.sv
// Two-flop synchroniser for an asynchronous level input plus edge detect
// against the previous synchronised sample.
//   clk, reset : clock, synchronous active-high reset
//   din        : asynchronous input
//   level      : synchronised sample (registered)
//   rise_c     : combinational, level went 0 -> 1 this cycle
//   fall_c     : combinational, level went 1 -> 0 this cycle
module line_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);
    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta  <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            meta  <= din;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise_c = level & ~prev;
    assign fall_c = ~level & prev;
endmodule

// File: rtl/ws2812_line_decoder.sv
// WS2812 line receiver: decodes high-pulse widths into bits, assembles GRB
// pixels, detects the latch gap closing each frame and flags protocol errors.
//   clk, reset : clock, synchronous active-high reset
//   line_in    : asynchronous WS2812 data line
//   bus        : report bus (pixel, frame, error strobes and held data)
module ws2812_line_decoder
    import leds_racer_pkg::*;
#(
    parameter int unsigned MAX_POS        = DEF_MAX_POS,
    parameter int unsigned T1_MIN_CLK     = DEF_T1_MIN_CLK,
    parameter int unsigned T_HIGH_MAX_CLK = DEF_T_HIGH_MAX_CLK,
    parameter int unsigned T_RESET_CLK    = DEF_T_RESET_CLK,
    parameter int unsigned IDX_W          = DEF_IDX_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   line_in,
    ws2812_line_decoder_if.master  bus
);
    localparam int unsigned LOW_W  = $clog2(T_RESET_CLK + 1);
    localparam int unsigned HIGH_W = $clog2(T_HIGH_MAX_CLK + 1);
    localparam int unsigned BIT_W  = $clog2(BITS_PER_PIXEL);
    localparam int unsigned SH_W   = BITS_PER_PIXEL - 1;

    logic level;
    logic rise_c;
    logic fall_c;

    line_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (line_in),
        .level  (level),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Decoder state; shift holds only the first 23 bits, the 24th joins on completion
    logic [1:0]       state_q,     state_d;
    logic [LOW_W-1:0] low_cnt_q,   low_cnt_d;
    logic [HIGH_W-1:0] high_cnt_q, high_cnt_d;
    logic [SH_W-1:0]  shift_q,     shift_d;
    logic [BIT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [IDX_W-1:0] pix_idx_q,   pix_idx_d;
    logic             got_bit_q,   got_bit_d;
    logic             ovf_q,       ovf_d;

    // Registered outputs
    logic             pixel_valid_q, pixel_valid_d;
    logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
    grb_t             pixel_grb_q,   pixel_grb_d;
    logic             frame_done_q,  frame_done_d;
    logic [IDX_W-1:0] frame_cnt_q,   frame_cnt_d;
    logic             err_valid_q,   err_valid_d;
    logic [1:0]       err_code_q,    err_code_d;

    logic bit_val;
    grb_t shifted;

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        low_cnt_d     = low_cnt_q;
        high_cnt_d    = high_cnt_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        pix_idx_d     = pix_idx_q;
        got_bit_d     = got_bit_q;
        ovf_d         = ovf_q;
        pixel_valid_d = 1'b0;
        pixel_index_d = pixel_index_q;
        pixel_grb_d   = pixel_grb_q;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_valid_d   = 1'b0;
        err_code_d    = err_code_q;

        bit_val = (high_cnt_q >= HIGH_W'(T1_MIN_CLK));
        shifted = {shift_q, bit_val};

        case (state_q)
            // Wait for a full latch gap before trusting bit boundaries
            ST_SYNC: begin
                if (level) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == LOW_W'(T_RESET_CLK - 1)) begin
                    low_cnt_d = LOW_W'(T_RESET_CLK);
                    state_d   = ST_LOW;
                end else begin
                    low_cnt_d = low_cnt_q + LOW_W'(1);
                end
            end

            ST_LOW: begin
                if (rise_c) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = HIGH_W'(1);
                end else if (low_cnt_q < LOW_W'(T_RESET_CLK)) begin
                    low_cnt_d = low_cnt_q + LOW_W'(1);
                    // Latch gap reached: close the frame if it carried any bit
                    if (low_cnt_q == LOW_W'(T_RESET_CLK - 1)) begin
                        if (got_bit_q) begin
                            frame_done_d = 1'b1;
                            frame_cnt_d  = pix_idx_q;
                            if (bit_cnt_q != '0) begin
                                err_valid_d = 1'b1;
                                err_code_d  = ERR_PARTIAL_PIXEL;
                            end
                        end
                        pix_idx_d = '0;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        got_bit_d = 1'b0;
                        ovf_d     = 1'b0;
                    end
                end
            end

            ST_HIGH: begin
                if (fall_c) begin
                    state_d   = ST_LOW;
                    low_cnt_d = LOW_W'(1);
                    shift_d   = shifted[SH_W-1:0];
                    got_bit_d = 1'b1;
                    if (bit_cnt_q == BIT_W'(BITS_PER_PIXEL - 1)) begin
                        bit_cnt_d = '0;
                        if (pix_idx_q < IDX_W'(MAX_POS)) begin
                            pixel_valid_d = 1'b1;
                            pixel_grb_d   = shifted;
                            pixel_index_d = pix_idx_q;
                            pix_idx_d     = pix_idx_q + IDX_W'(1);
                        end else if (!ovf_q) begin
                            // Only the first excess pixel of a frame is reported
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_PIXEL_OVERFLOW;
                            ovf_d       = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else if (high_cnt_q == HIGH_W'(T_HIGH_MAX_CLK - 1)) begin
                    // Line stuck high: drop the frame and resynchronise
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_HIGH_TOO_LONG;
                    state_d     = ST_SYNC;
                    low_cnt_d   = '0;
                    pix_idx_d   = '0;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    got_bit_d   = 1'b0;
                    ovf_d       = 1'b0;
                end else begin
                    high_cnt_d = high_cnt_q + HIGH_W'(1);
                end
            end

            default: begin
                state_d   = ST_SYNC;
                low_cnt_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SYNC;
            low_cnt_q     <= '0;
            high_cnt_q    <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pix_idx_q     <= '0;
            got_bit_q     <= 1'b0;
            ovf_q         <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_index_q <= '0;
            pixel_grb_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            err_valid_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            low_cnt_q     <= low_cnt_d;
            high_cnt_q    <= high_cnt_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_idx_q     <= pix_idx_d;
            got_bit_q     <= got_bit_d;
            ovf_q         <= ovf_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_index_q <= pixel_index_d;
            pixel_grb_q   <= pixel_grb_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
        end
    end

    assign bus.pixel_valid       = pixel_valid_q;
    assign bus.pixel_index       = pixel_index_q;
    assign bus.pixel_grb         = pixel_grb_q;
    assign bus.frame_done        = frame_done_q;
    assign bus.frame_pixel_count = frame_cnt_q;
    assign bus.err_valid         = err_valid_q;
    assign bus.err_code          = err_code_q;
endmodule

// File: tb/tb_ws2812_line_decoder.sv
// Scoreboard bench for ws2812_line_decoder: stimulus tasks push expected
// report events computed from frame bit counts; a negedge monitor pops and
// compares whenever the decoder strobes.
module tb_ws2812_line_decoder;
    import leds_racer_pkg::*;

    localparam int unsigned MAX_POS = 109;
    localparam int unsigned IDX_W   = 7;
    localparam int          GAP     = 2520;

    logic clk = 1'b0;
    logic reset;
    logic line_in;

    ws2812_line_decoder_if #(.IDX_W(IDX_W)) bus ();

    ws2812_line_decoder #(
        .MAX_POS        (MAX_POS),
        .T1_MIN_CLK     (30),
        .T_HIGH_MAX_CLK (100),
        .T_RESET_CLK    (2500),
        .IDX_W          (IDX_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .line_in (line_in),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic        fd;
        logic        ev;
        int          idx;
        logic [23:0] grb;
        int          cnt;
        logic [1:0]  code;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  frame_bits = 0;   // bits received since the last latch, per the model
    int  held_cnt = 0;
    int  held_code = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_ev(input logic pv, input logic fd, input logic ev, input int idx,
                           input logic [23:0] grb, input int cnt, input logic [1:0] code);
        ev_t e;
        e.pv = pv; e.fd = fd; e.ev = ev; e.idx = idx; e.grb = grb; e.cnt = cnt; e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic model_pixel(input logic [23:0] grb);
        int idx;
        idx = frame_bits / 24;
        if (idx < int'(MAX_POS)) push_ev(1'b1, 1'b0, 1'b0, idx, grb, 0, 2'b00);
        else if (idx == int'(MAX_POS)) push_ev(1'b0, 1'b0, 1'b1, 0, 24'h0, 0, 2'b11);
        frame_bits += 24;
    endtask

    task automatic model_latch();
        int pix;
        if (frame_bits > 0) begin
            pix = frame_bits / 24;
            if (pix > int'(MAX_POS)) pix = int'(MAX_POS);
            push_ev(1'b0, 1'b1, (frame_bits % 24) != 0, 0, 24'h0, pix, 2'b10);
        end
        frame_bits = 0;
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input int n);
        line_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: nominal timing, 1: randomised timing, 2: fast minimal timing
    task automatic send_bit(input logic b, input int mode);
        int hi;
        int lo;
        case (mode)
            0: begin hi = b ? 40 : 20; lo = b ? 22 : 42; end
            1: begin
                hi = b ? int'($urandom_range(30, 45)) : int'($urandom_range(2, 25));
                lo = int'($urandom_range(2, 10));
            end
            default: begin hi = b ? 31 : 2; lo = 2; end
        endcase
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    task automatic send_pixel(input logic [23:0] grb, input int mode);
        model_pixel(grb);
        for (int i = 23; i >= 0; i--) send_bit(grb[i], mode);
    endtask

    task automatic send_partial(input int n, input int mode);
        frame_bits += n;
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), mode);
    endtask

    task automatic latch();
        model_latch();
        drive(1'b0, GAP);
    endtask

    task automatic stuck_high();
        push_ev(1'b0, 1'b0, 1'b1, 0, 24'h0, 0, 2'b01);
        frame_bits = 0;
        drive(1'b1, 120);
        drive(1'b0, GAP);
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        chk({tag, "_pixel_valid"}, 32'(bus.pixel_valid), 32'd0);
        chk({tag, "_pixel_index"}, 32'(bus.pixel_index), 32'd0);
        chk({tag, "_pixel_grb"},   32'(bus.pixel_grb),   32'd0);
        chk({tag, "_frame_done"},  32'(bus.frame_done),  32'd0);
        chk({tag, "_frame_count"}, 32'(bus.frame_pixel_count), 32'd0);
        chk({tag, "_err_valid"},   32'(bus.err_valid),   32'd0);
        chk({tag, "_err_code"},    32'(bus.err_code),    32'd0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()),    32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic line_level, input string tag);
        line_in = line_level;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        frame_bits = 0;
        held_cnt   = 0;
        held_code  = 0;
        check_outputs_zero(tag);
        reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    ev_t mon_e;
    always @(negedge clk) begin
        if (!reset && (bus.pixel_valid || bus.frame_done || bus.err_valid)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'({bus.pixel_valid, bus.frame_done, bus.err_valid}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pixel_valid", 32'(bus.pixel_valid), 32'(mon_e.pv));
                chk("frame_done",  32'(bus.frame_done),  32'(mon_e.fd));
                chk("err_valid",   32'(bus.err_valid),   32'(mon_e.ev));
                if (mon_e.pv) begin
                    chk("pixel_index", 32'(bus.pixel_index), 32'(mon_e.idx));
                    chk("pixel_grb",   32'(bus.pixel_grb),   32'(mon_e.grb));
                end
                if (mon_e.fd) begin
                    chk("frame_pixel_count", 32'(bus.frame_pixel_count), 32'(mon_e.cnt));
                    held_cnt = mon_e.cnt;
                end else begin
                    chk("frame_count_held", 32'(bus.frame_pixel_count), 32'(held_cnt));
                end
                if (mon_e.ev) begin
                    chk("err_code", 32'(bus.err_code), 32'(mon_e.code));
                    held_code = int'(mon_e.code);
                end else begin
                    chk("err_code_held", 32'(bus.err_code), 32'(held_code));
                end
            end
        end
    end

    // Hard bound on total run time
    initial begin
        #1500000;
        $display("FAIL watchdog: run did not complete, expected events left %0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [23:0] px;
        int          npix;

        do_reset(1'b0, "reset");
        drive(1'b0, GAP);

        // Single pixel, nominal timing
        send_pixel(24'hFF0080, 0);
        latch();

        // Three pixels, then the same frame again with jittered timing
        send_pixel(24'h000001, 0);
        send_pixel(24'h800000, 0);
        send_pixel(24'h00FF00, 0);
        latch();
        send_pixel(24'h000001, 1);
        send_pixel(24'h800000, 1);
        send_pixel(24'h00FF00, 1);
        latch();

        // Start mid-frame with the line high: nothing decodes until a full gap
        do_reset(1'b1, "reset_high");
        drive(1'b1, 50);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), 1);
        drive(1'b0, GAP);
        px = 24'($urandom);
        send_pixel(px, 1);
        latch();

        // Partial pixel at latch: frame_done count 0 with err 10
        send_partial(12, 1);
        latch();

        // Line stuck high mid-pixel, then recovery at index 0
        send_partial(5, 1);
        stuck_high();
        px = 24'($urandom);
        send_pixel(px, 1);
        latch();

        // Random frame with an optional trailing partial pixel, then an empty gap
        npix = int'($urandom_range(1, 3));
        for (int p = 0; p < npix; p++) send_pixel(24'($urandom), 1);
        if ($urandom_range(0, 1) == 1) send_partial(int'($urandom_range(1, 23)), 2);
        latch();
        latch();

        // Overflow: 110 pixels into a 109-pixel strip
        for (int p = 0; p < 110; p++) send_pixel(24'($urandom & $urandom & $urandom), 2);
        latch();

        // Reset in the middle of pixel 5
        for (int p = 0; p < 5; p++) send_pixel(24'($urandom & $urandom), 2);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 2);
        do_reset(1'b0, "reset_mid");
        drive(1'b0, GAP);
        px = 24'($urandom);
        send_pixel(px, 1);
        latch();

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
